// File: rtl/bram_access_controller.sv
// ---------------------------------------------------------------------------
// bram_access_controller
//
// Shares four byte-wide, sync-read BRAM banks between an instruction-fetch
// port and a data port. A byte address A lives in bank A[1:0] at word
// A[ADDR_W-1:2]. A 32-bit access touches bytes A..A+3, so a misaligned access
// rotates across the banks and may step into the next word (wrapping at the
// top of the bank). Byte 0 of an access travels on data[31:24].
//
// Each access takes two cycles: an IDLE grant cycle drives the banks, then a
// single BUSY cycle returns the de-rotated read data with the owner's ack.
// The data port normally wins arbitration; after two back-to-back data grants
// made while fetch was waiting, fetch gets the next slot.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   if_req/if_addr       fetch request (held until if_ack), word-aligned use
//   if_ack/if_rdata      fetch completion pulse and word (0 when no ack)
//   dm_req/dm_addr       data request (held with all dm_* stable until dm_ack)
//   dm_code              {byte_enable[3:0], store}; enable[3] = data[31:24]
//   dm_wdata             store data
//   dm_ack/dm_rdata      data completion pulse and load word (0 when no ack)
//   bank_addr            per-bank word address, bank b at [16b+15:16b]
//   bank_we              per-bank write enable
//   bank_wdata           per-bank write byte, bank b at [8b+7:8b]
//   bank_rdata           per-bank read byte, one cycle after the address
//   busy                 high during the BUSY (ack) cycle
// ---------------------------------------------------------------------------
module bram_access_controller #(
    parameter int ADDR_W = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic                    if_ack,
    output logic [31:0]             if_rdata,
    input  logic                    dm_req,
    input  logic [ADDR_W-1:0]       dm_addr,
    input  logic [4:0]              dm_code,
    input  logic [31:0]             dm_wdata,
    output logic                    dm_ack,
    output logic [31:0]             dm_rdata,
    output logic [4*(ADDR_W-2)-1:0] bank_addr,
    output logic [3:0]              bank_we,
    output logic [31:0]             bank_wdata,
    input  logic [31:0]             bank_rdata,
    output logic                    busy
);

    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [1:0]  streak_q, streak_d;   // consecutive data grants made while fetch waited
    logic [1:0]  lo_q, lo_d;           // A[1:0] of the access in flight
    logic [3:0]  be_q, be_d;           // byte enables of the access in flight

    logic              grant_dm, grant_if, grant;
    logic [WORD_W-1:0] acc_word;
    logic [1:0]        acc_lo;
    logic [3:0]        acc_be;
    logic              acc_store;
    logic [1:0]        wk, wsel;       // write path: byte index for a bank, and 3-k
    logic [1:0]        rk, rsel;       // read path: bank for a byte, and 3-k
    logic [31:0]       rdata_word;
    logic              ack;

    // Fetch addresses are word-aligned by definition; the low bits are dropped.
    logic unused_if_lo;
    assign unused_if_lo = &{1'b0, if_addr[1:0]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_FETCH;
            streak_q <= '0;
            lo_q     <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            lo_q     <= lo_d;
            be_q     <= be_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and arbitration
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        lo_d     = lo_q;
        be_d     = be_q;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req && !(streak_q == 2'd2 && if_req)) begin
                    grant_dm = 1'b1;
                    owner_d  = OWNER_DATA;
                    // Only grants that made fetch wait count toward its turn.
                    streak_d = if_req ? streak_q + 2'd1 : 2'd0;
                    lo_d     = dm_addr[1:0];
                    be_d     = dm_code[4:1];
                    state_d  = BUSY;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    owner_d  = OWNER_FETCH;
                    streak_d = 2'd0;
                    lo_d     = 2'b00;
                    be_d     = 4'b1111;
                    state_d  = BUSY;
                end else begin
                    streak_d = 2'd0;
                end
            end
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant = grant_dm | grant_if;

    // -----------------------------------------------------------------------
    // Grant-cycle bank drive: rotate access bytes onto the banks
    // -----------------------------------------------------------------------
    always_comb begin
        acc_word   = grant_dm ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        acc_lo     = grant_dm ? dm_addr[1:0] : 2'b00;
        acc_be     = grant_dm ? dm_code[4:1] : 4'b1111;
        acc_store  = grant_dm & dm_code[0];
        bank_addr  = '0;
        bank_we    = '0;
        bank_wdata = '0;
        wk         = '0;
        wsel       = '0;
        if (grant && !reset) begin
            for (int b = 0; b < 4; b++) begin
                // Bank b carries access byte k = b - A[1:0] (mod 4); banks
                // below A[1:0] hold the bytes that spilled into the next word.
                wk   = 2'(b) - acc_lo;
                wsel = ~wk;
                bank_addr[WORD_W*b +: WORD_W] = acc_word + WORD_W'(2'(b) < acc_lo);
                bank_wdata[8*b +: 8]          = dm_wdata[{wsel, 3'b000} +: 8];
                bank_we[b]                    = acc_store & acc_be[wsel];
            end
        end
    end

    // -----------------------------------------------------------------------
    // BUSY cycle: de-rotate the bank bytes and acknowledge the owner
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_word = '0;
        rk         = '0;
        rsel       = '0;
        for (int k = 0; k < 4; k++) begin
            rk   = lo_q + 2'(k);
            rsel = ~2'(k);
            if (be_q[rsel]) begin
                rdata_word[{rsel, 3'b000} +: 8] = bank_rdata[{rk, 3'b000} +: 8];
            end
        end
        ack      = (state_q == BUSY) && !reset;
        busy     = ack;
        if_ack   = ack && (owner_q == OWNER_FETCH);
        dm_ack   = ack && (owner_q == OWNER_DATA);
        if_rdata = if_ack ? rdata_word : 32'h0;
        dm_rdata = dm_ack ? rdata_word : 32'h0;
    end

endmodule

// File: tb/tb_bram_access_controller.sv
// ---------------------------------------------------------------------------
// tb_bram_access_controller
//
// Reference model: a flat byte-addressed memory plus a transaction-level view
// of arbitration (who is granted, one-cycle ack after grant). Four banks of
// BRAM are emulated behind the DUT; both memories start from the same
// address-derived pattern so loads of unwritten bytes are predictable.
// Directed scenarios run first, then randomized request traffic.
// ---------------------------------------------------------------------------
module tb_bram_access_controller;

    localparam int ADDR_W = 18;
    localparam int NBYTES = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic [17:0] dm_addr = '0;
    logic [4:0]  dm_code = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [63:0] bank_addr;
    logic [3:0]  bank_we;
    logic [31:0] bank_wdata;
    logic [31:0] bank_rdata = '0;
    logic        busy;

    bram_access_controller #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_code    (dm_code),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .bank_addr  (bank_addr),
        .bank_we    (bank_we),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Initial content of byte address a, shared by the BRAM and the model.
    function automatic logic [7:0] init_byte(input logic [17:0] a);
        logic [17:0] t;
        t = a * 18'd151;
        return t[7:0] ^ a[17:10];
    endfunction

    // ---------------- emulated BRAM banks (read-first, 1-cycle latency) ----
    logic [7:0] bram    [4][65536];
    bit         bram_wr [4][65536];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_we[b]) begin
                bram[b][bank_addr[16*b +: 16]]    <= bank_wdata[8*b +: 8];
                bram_wr[b][bank_addr[16*b +: 16]] <= 1'b1;
            end
            bank_rdata[8*b +: 8] <= bram_wr[b][bank_addr[16*b +: 16]]
                                    ? bram[b][bank_addr[16*b +: 16]]
                                    : init_byte({bank_addr[16*b +: 16], 2'(b)});
        end
    end

    // ---------------- reference model ------------------------------------
    logic [7:0] ref_mem [NBYTES];
    bit         ref_wr  [NBYTES];

    function automatic logic [7:0] ref_byte(input logic [17:0] ba);
        return ref_wr[ba] ? ref_mem[ba] : init_byte(ba);
    endfunction

    bit          m_busy = 1'b0;
    bit          m_owner_dm, m_owner_store;
    int          m_streak = 0;
    logic [31:0] m_exp_rdata;
    bit          if_done, dm_done;
    int          cyc = 0, grant_cyc = 0, ack_cyc = 0;
    logic [3:0]  snap_we;
    logic [63:0] snap_addr;
    logic [31:0] snap_wdata, snap_rdata;
    logic        snap_dm_ack;
    bit          grant_log[$];

    // One clock cycle of checking, sampled on the falling edge.
    task automatic tick_check();
        logic [17:0] a, ba;
        logic [3:0]  be, e_we;
        logic [63:0] e_addr;
        logic [31:0] e_wdata, wmask, e_rd;
        bit          is_dm, is_store;
        int          bk;
        @(negedge clk);
        cyc++;
        if_done = 1'b0;
        dm_done = 1'b0;
        if (reset) begin
            check("rst_if_ack", if_ack, 0);
            check("rst_dm_ack", dm_ack, 0);
            check("rst_busy", busy, 0);
            check("rst_bank_we", bank_we, 0);
            check("rst_rdata", {if_rdata, dm_rdata}, 0);
            snap_dm_ack = dm_ack;
            snap_we     = bank_we;
            m_busy      = 1'b0;
            m_streak    = 0;
        end else if (m_busy) begin
            check("busy_hi", busy, 1);
            check("we_in_busy", bank_we, 0);
            check("if_ack", if_ack, !m_owner_dm);
            check("dm_ack", dm_ack, m_owner_dm);
            if (m_owner_dm) begin
                check("if_rdata_noack", if_rdata, 0);
                if (!m_owner_store) check("dm_rdata", dm_rdata, m_exp_rdata);
                dm_done = 1'b1;
            end else begin
                check("dm_rdata_noack", dm_rdata, 0);
                check("if_rdata", if_rdata, m_exp_rdata);
                if_done = 1'b1;
            end
            snap_rdata  = m_owner_dm ? dm_rdata : if_rdata;
            snap_dm_ack = dm_ack;
            ack_cyc     = cyc;
            m_busy      = 1'b0;
        end else begin
            check("idle_busy", busy, 0);
            check("idle_acks", {if_ack, dm_ack}, 0);
            check("idle_rdata", {if_rdata, dm_rdata}, 0);
            is_dm = dm_req && !(m_streak == 2 && if_req);
            if (!is_dm && !if_req) begin
                check("we_no_req", bank_we, 0);
                m_streak = 0;
            end else begin
                a        = is_dm ? dm_addr : {if_addr[17:2], 2'b00};
                be       = is_dm ? dm_code[4:1] : 4'hF;
                is_store = is_dm && dm_code[0];
                e_addr = '0; e_we = '0; e_wdata = '0; wmask = '0; e_rd = '0;
                for (int k = 0; k < 4; k++) begin
                    ba = a + 18'(k);
                    bk = int'(ba[1:0]);
                    e_addr[16*bk +: 16] = ba[17:2];
                    if (be[3-k]) e_rd[31-8*k -: 8] = ref_byte(ba);
                    if (is_store && be[3-k]) begin
                        e_we[bk]             = 1'b1;
                        e_wdata[8*bk +: 8]   = dm_wdata[31-8*k -: 8];
                        wmask[8*bk +: 8]     = 8'hFF;
                    end
                end
                check("bank_addr", bank_addr, e_addr);
                check("bank_we", bank_we, e_we);
                check("bank_wdata", bank_wdata & wmask, e_wdata);
                for (int k = 0; k < 4; k++) begin
                    ba = a + 18'(k);
                    if (is_store && be[3-k]) begin
                        ref_mem[ba] = dm_wdata[31-8*k -: 8];
                        ref_wr[ba]  = 1'b1;
                    end
                end
                snap_we    = bank_we;
                snap_addr  = bank_addr;
                snap_wdata = bank_wdata;
                grant_log.push_back(is_dm);
                grant_cyc     = cyc;
                m_busy        = 1'b1;
                m_owner_dm    = is_dm;
                m_owner_store = is_store;
                m_exp_rdata   = e_rd;
                m_streak      = is_dm ? (if_req ? m_streak + 1 : 0) : 0;
            end
        end
    endtask

    task automatic tick_end();
        @(posedge clk);
        #1;
    endtask

    // Issue one data access and wait (bounded) for its ack.
    task automatic run_dm(input logic [17:0] a, input logic [4:0] c, input logic [31:0] d);
        int n;
        dm_req   = 1'b1;
        dm_addr  = a;
        dm_code  = c;
        dm_wdata = d;
        n = 0;
        do begin
            tick_check();
            tick_end();
            n++;
        end while (!dm_done && n < 8);
        check("dm_acked", dm_done, 1);
        check("ack_latency", 64'(ack_cyc - grant_cyc), 1);
        dm_req = 1'b0;
    endtask

    function automatic logic [17:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 18'($urandom_range(0, 63));
            1:       return 18'(NBYTES - 1 - $urandom_range(0, 31));
            default: return 18'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] order;
        int n;

        // Reset behaviour
        reset = 1'b1;
        repeat (2) begin tick_check(); tick_end(); end
        reset = 1'b0;
        tick_check();
        check("busy_after_reset", busy, 0);
        tick_end();

        // Aligned store then load
        run_dm(18'h00010, 5'b11111, 32'hDEADBEEF);
        check("st_al_we", snap_we, 4'b1111);
        check("st_al_addr", snap_addr, {4{16'h0004}});
        run_dm(18'h00010, 5'b11110, 32'h0);
        check("ld_al_rdata", snap_rdata, 32'hDEADBEEF);

        // Misaligned halfword store spanning a word boundary
        run_dm(18'h00013, 5'b11001, 32'hABCD0000);
        check("st_mis_we", snap_we, 4'b1001);
        check("st_mis_addr_b3", snap_addr[63:48], 16'h0004);
        check("st_mis_addr_b0", snap_addr[15:0], 16'h0005);
        check("st_mis_bytes", {snap_wdata[31:24], snap_wdata[7:0]}, 16'hABCD);
        run_dm(18'h00013, 5'b11000, 32'h0);
        check("ld_mis_rdata", snap_rdata, 32'hABCD0000);

        // Word-index wrap at the top of the banks
        run_dm(18'h3FFFE, 5'b11110, 32'h0);
        check("wrap_addr", snap_addr, 64'hFFFF_FFFF_0000_0000);
        check("wrap_rdata", snap_rdata,
              {ref_byte(18'h3FFFE), ref_byte(18'h3FFFF), ref_byte(18'h0), ref_byte(18'h1)});

        // Contention: both ports held high
        tick_check(); tick_end();
        grant_log.delete();
        if_req = 1'b1; if_addr = 18'h00100;
        dm_req = 1'b1; dm_addr = 18'h00010; dm_code = 5'b11110;
        for (int i = 0; i < 20 && grant_log.size() < 6; i++) begin
            tick_check(); tick_end();
        end
        check("arb_grants", grant_log.size() >= 6, 1);
        if (grant_log.size() >= 6) begin
            order = {grant_log[0], grant_log[1], grant_log[2],
                     grant_log[3], grant_log[4], grant_log[5]};
            check("arb_order", order, 6'b110110);
        end
        tick_check(); tick_end();
        if_req = 1'b0; dm_req = 1'b0;
        tick_check(); tick_end();

        // Reset while BUSY with a load: no ack, then the held request retries
        dm_req = 1'b1; dm_addr = 18'h00010; dm_code = 5'b11110;
        tick_check();
        check("rb_granted", grant_cyc, cyc);
        tick_end();
        reset = 1'b1;
        tick_check();
        check("rb_no_ack", snap_dm_ack, 0);
        check("rb_no_we", snap_we, 0);
        tick_end();
        reset = 1'b0;
        n = 0;
        do begin tick_check(); tick_end(); n++; end while (!dm_done && n < 6);
        check("rb_acked", dm_done, 1);
        check("rb_rdata", snap_rdata, 32'hDEADBEAB);
        dm_req = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = (i % 700 == 350);
            if (if_done || !if_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    if_req  = 1'b1;
                    if_addr = rand_addr();
                end else begin
                    if_req = 1'b0;
                end
            end
            if (dm_done || !dm_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    dm_req   = 1'b1;
                    dm_addr  = rand_addr();
                    dm_code  = 5'($urandom);
                    dm_wdata = $urandom;
                end else begin
                    dm_req = 1'b0;
                end
            end
            tick_check();
            tick_end();
        end
        reset = 1'b0;
        repeat (3) begin tick_check(); tick_end(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_access_controller.md
BRAM_ACCESS_CONTROLLER -- requirements
Module: bram_access_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, byte-address width; bank word address width is ADDR_W-2 (16).
REQ-002 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_req  input  1  fetch-port request, held until if_ack.
REQ-005 SHALL have port if_addr  input  ADDR_W  fetch byte address; bits [1:0] are ignored and treated as 0.
REQ-006 SHALL have port if_ack  output  1  fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  fetched word, valid only while if_ack=1.
REQ-008 SHALL have port dm_req  input  1  data-port request, held with all dm_* inputs stable until dm_ack.
REQ-009 SHALL have port dm_addr  input  ADDR_W  data byte address; any alignment is allowed.
REQ-010 SHALL have port dm_code  input  5  memory_access_code: bit0 = store, bits[4:1] = byte_enable, with [4] for data[31:24] down to [1] for data[7:0].
REQ-011 SHALL have port dm_wdata  input  32  store data.
REQ-012 SHALL have port dm_ack  output  1  data completion pulse.
REQ-013 SHALL have port dm_rdata  output  32  load data, valid only while dm_ack=1.
REQ-014 SHALL have port bank_addr  output  4x16 (64)  word address per bank; bank b uses bits [16b+15:16b].
REQ-015 SHALL have port bank_we  output  4  per-bank write enable.
REQ-016 SHALL have port bank_wdata  output  32  per-bank write byte; bank b uses bits [8b+7:8b].
REQ-017 SHALL have port bank_rdata  input  32  per-bank read byte, sync-read BRAM with 1-cycle latency.
REQ-018 SHALL have port busy  output  1  high while the FSM is in BUSY.

Function
REQ-019 SHALL map byte address A to bank A[1:0], word A[ADDR_W-1:2].
REQ-020 SHALL map access byte k (k=0..3) to byte address A+k, with k=0 carried on data[31:24]; the word index SHALL wrap modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-021 SHALL implement a 2-state FSM: IDLE and BUSY.
REQ-022 IDLE with any request: SHALL grant one requester, drive bank_addr, bank_we and bank_wdata combinationally in that cycle, latch the owner, A[1:0] and byte_enable, then go to BUSY.
REQ-023 BUSY SHALL last exactly 1 cycle: assert the owner's ack, drive rdata by de-rotating bank_rdata, and then return to IDLE.
REQ-024 Throughput SHALL be at most one access per 2 cycles; ack SHALL occur exactly 1 cycle after grant.
REQ-025 bank_we[b] SHALL be 1 only in an IDLE grant cycle of a data store, for a bank whose mapped byte k has byte_enable bit set.
REQ-026 Fetch grants and loads SHALL never assert bank_we.
REQ-027 Fetch accesses SHALL use all four byte enables.
REQ-028 Loads SHALL return byte k at data[31-8k -: 8] when enabled and 0x00 otherwise; no sign extension.
REQ-029 Arbitration: dm_req SHALL win over if_req, except that after 2 consecutive data grants with if_req high throughout, the next grant SHALL go to fetch.
REQ-030 A 2-bit streak counter SHALL track consecutive data grants; it SHALL clear on any fetch grant, and on any idle cycle with no request.
REQ-031 Requests raised during BUSY SHALL be considered only in the following IDLE cycle.
REQ-032 if_ack and dm_ack SHALL never both be 1 in the same cycle.
REQ-033 busy SHALL be 1 in BUSY and 0 in IDLE.

Reset
REQ-034 On reset=1 at a clock edge: state SHALL become IDLE, streak counter 0, owner latch cleared.
REQ-035 Reset SHALL force if_ack, dm_ack, bank_we and busy to 0 during and immediately after reset.
REQ-036 Reset in BUSY SHALL abort the access with no ack; the requester re-arbitrates after reset.
REQ-037 if_rdata and dm_rdata SHALL read 0 whenever the corresponding ack is 0.

Verification
REQ-038 Aligned store, then load: dm_addr=0x00010, code=5'b11111, wdata=0xDEADBEEF -> bank_we=4'b1111 and all bank_addr=0x0004; the following load returns dm_rdata=0xDEADBEEF with dm_ack 1 cycle after grant.
REQ-039 Misaligned halfword store: addr=0x00013, code=5'b11001, wdata=0xABCD0000 -> bank3 word 0x0004 gets 0xAB, bank0 word 0x0005 gets 0xCD, bank_we=4'b1001.
REQ-040 Wrap-around load: addr=0x3FFFE, byte_enable=1111 -> bank2,3 at 0xFFFF and bank0,1 at 0x0000; dm_rdata concatenates the bytes in that order.
REQ-041 Contention: if_req and dm_req held high continuously -> grant order data, data, fetch, data, data, fetch; the acks never overlap.
REQ-042 Reset in BUSY during a load -> no dm_ack, bank_we=0; after reset deasserts, the held dm_req is granted and acked normally.
